// File: rtl/stack_unit_pkg.sv
// Shared stack parameters, opcode constants and request decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_unit_pkg;

    // Default geometry; kept beside the stack opcodes so the decoder and the unit agree.
    localparam int STACK_DEPTH_DEF = 64;
    localparam int STACK_AW_DEF    = 6;

    // Stack instruction opcodes seen by the ID stage.
    localparam logic [5:0] PUSHi = 6'h38;
    localparam logic [5:0] POPi  = 6'h39;

    // Per-cycle stack operation after kill qualification.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_XCHG = 2'd3
    } op_e;

    function automatic op_e op_decode(input logic push_e, input logic pop_e);
        case ({push_e, pop_e})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_XCHG;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x 32 with one synchronous write and one synchronous read port.
// Latency: read data appears one cycle after rd_en; same-address read/write returns old data.
// Backpressure: none; rd_data holds when rd_en is low.
module stack_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Write and read in one edge; non-blocking update gives read-old-data on collision.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/stack_unit.sv
// Hardware call/data stack for the EX stage: push, pop, exchange, sticky over/underflow flags.
// Latency: pop_data valid the cycle after an effective pop; push visible to a pop in the next cycle.
// Backpressure: none; pushes while full and pops while empty are dropped and flagged.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int STACK_AW    = STACK_AW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                kill,
    input  logic [31:0]         push_data,
    output logic [31:0]         pop_data,
    output logic [STACK_AW:0]   sp,
    output logic                full,
    output logic                empty,
    output logic                ovfl,
    output logic                unfl
);

    op_e                 op;
    logic [STACK_AW-1:0] top_idx;
    logic [STACK_AW:0]   sp_nxt;
    logic                wr_en;
    logic [STACK_AW-1:0] wr_addr;
    logic                rd_en;
    logic                ovfl_set;
    logic                unfl_set;
    logic                zero_sel;
    logic [31:0]         rd_data;

    assign op      = op_decode(push & ~kill, pop & ~kill);
    assign full    = (sp == (STACK_AW+1)'(STACK_DEPTH));
    assign empty   = (sp == '0);
    // sp==DEPTH truncates to 0, so subtracting one still lands on the last entry.
    assign top_idx = sp[STACK_AW-1:0] - STACK_AW'(1);

    // Decode the effective operation into RAM strobes, next pointer and flag sets.
    always_comb begin
        sp_nxt   = sp;
        wr_en    = 1'b0;
        wr_addr  = sp[STACK_AW-1:0];
        rd_en    = 1'b0;
        ovfl_set = 1'b0;
        unfl_set = 1'b0;
        case (op)
            OP_PUSH: begin
                if (full) begin
                    ovfl_set = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    sp_nxt = sp + 1'b1;
                end
            end
            OP_POP: begin
                if (empty) begin
                    unfl_set = 1'b1;
                end else begin
                    rd_en  = 1'b1;
                    sp_nxt = sp - 1'b1;
                end
            end
            OP_XCHG: begin
                if (empty) begin
                    // Nothing to return: degrade to a plain push and flag the pop.
                    wr_en    = 1'b1;
                    sp_nxt   = sp + 1'b1;
                    unfl_set = 1'b1;
                end else begin
                    // Read old top and overwrite it in the same edge.
                    wr_en   = 1'b1;
                    wr_addr = top_idx;
                    rd_en   = 1'b1;
                end
            end
            default: ;
        endcase
        // Reset wins over any request in the same cycle.
        if (!rst_n) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    stack_mem #(
        .DEPTH (STACK_DEPTH),
        .AW    (STACK_AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (push_data),
        .rd_en   (rd_en),
        .rd_addr (top_idx),
        .rd_data (rd_data)
    );

    // Pointer, sticky flags and the zero-select that masks stale RAM data after reset/underflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp       <= '0;
            ovfl     <= 1'b0;
            unfl     <= 1'b0;
            zero_sel <= 1'b1;
        end else begin
            sp <= sp_nxt;
            if (ovfl_set) ovfl <= 1'b1;
            if (unfl_set) unfl <= 1'b1;
            if (rd_en)         zero_sel <= 1'b0;
            else if (unfl_set) zero_sel <= 1'b1;
        end
    end

    assign pop_data = zero_sel ? 32'h0 : rd_data;

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 64, number of 32-bit entries (power of two).
REQ-002 SHALL have parameter STACK_AW, default 6, log2(STACK_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 push  input  1  push request from EX stage (stack_push_ID_EX).
REQ-006 pop  input  1  pop request from EX stage (stack_pop_ID_EX).
REQ-007 kill  input  1  flush qualifier; when high, push and pop are ignored that cycle.
REQ-008 push_data  input  32  value to push (EX-stage src1 operand).
REQ-009 pop_data  output  32  popped value, registered, consumed in DM stage by dst_mux.
REQ-010 sp  output  STACK_AW+1  current occupancy, 0..STACK_DEPTH.
REQ-011 full  output  1  high when sp==STACK_DEPTH.
REQ-012 empty  output  1  high when sp==0.
REQ-013 ovfl  output  1  sticky: a push was attempted while full.
REQ-014 unfl  output  1  sticky: a pop was attempted while empty.

Function
REQ-015 Effective requests SHALL be push_e = push & !kill, pop_e = pop & !kill.
REQ-016 Push only, not full: SHALL write push_data to entry sp at posedge, sp <= sp+1.
REQ-017 Push only, full: SHALL not write, sp unchanged, ovfl <= 1.
REQ-018 Pop only, not empty: SHALL read entry sp-1, sp <= sp-1; pop_data valid the cycle after pop (1-cycle latency).
REQ-019 Pop only, empty: SHALL leave sp unchanged, pop_data <= 0 next cycle, unfl <= 1.
REQ-020 Push and pop same cycle, not empty: SHALL return old top on pop_data next cycle, overwrite top with push_data, sp unchanged (exchange).
REQ-021 Push and pop same cycle, empty: SHALL behave as push only; pop_data <= 0, unfl <= 1.
REQ-022 pop_data SHALL hold its value in cycles with no effective pop.
REQ-023 Push in cycle N followed by pop in cycle N+1 SHALL return the value pushed in N (no extra bypass cycle).
REQ-024 kill high SHALL suppress all state changes including sticky flags; pop_data holds.
REQ-025 full, empty SHALL be combinational decodes of registered sp; sp SHALL never wrap.
REQ-026 ovfl, unfl SHALL clear only on reset.

Reset
REQ-027 On posedge clk with rst_n low: sp=0, pop_data=0, ovfl=0, unfl=0, so empty=1, full=0.
REQ-028 Reset SHALL override push/pop in the same cycle; memory contents are not cleared and are unobservable after reset.
REQ-029 Reset asserted mid-sequence SHALL discard all entries; next pop returns 0 with unfl set.

Structure
REQ-030 STACK_DEPTH and STACK_AW defaults SHALL be added to common_params.inc alongside the opcode constants (PUSHi, POPi).
REQ-031 Storage SHALL be a sub-module stack_mem: STACK_DEPTH x 32, one sync write port, one sync read port, read-old-data on same-address read/write.
REQ-032 stack_unit SHALL contain pointer, flag and pop_data-select logic only; pop_data forced to 0 on underflow via registered select, not RAM contents.

Verification
REQ-033 Reset, push 0x11111111, 0x22222222, 0x33333333, pop x3 -> pop_data 0x33333333, 0x22222222, 0x11111111 on cycles after each pop; sp 3->0; empty=1.
REQ-034 Push 64 values 0..63 then push 0xDEADBEEF -> full=1, ovfl=1, sp=64; 64 pops return 63..0, 0xDEADBEEF never seen.
REQ-035 Empty stack, pop -> pop_data=0x00000000 next cycle, unfl=1, sp=0; subsequent push 0x5 then pop returns 0x5, unfl stays 1.
REQ-036 Stack holds 0xA,0xB; push 0xC and pop same cycle -> pop_data=0xB, sp=2; next pop -> 0xC, then 0xA.
REQ-037 push=1 with kill=1 for 0x77, then pop -> pop_data=0, unfl=1, sp=0 (killed push not stored); pop with kill=1 on non-empty stack -> sp and pop_data unchanged.
REQ-038 Push 3 values, assert rst_n=0 one cycle with push=1 -> sp=0, ovfl=unfl=0, pop_data=0; next pop -> unfl=1.
